// File: rtl/im2col_pkg.sv
// Shared definitions for the im2col blocks: derived window geometry and the stream FSM states.
package im2col_pkg;

  typedef enum logic {StLoad, StEmit} state_e;

  function automatic int calc_out_dim(int img, int k, int s, int p);
    return (img - k + 2 * p) / s + 1;
  endfunction

  function automatic int calc_hp(int w, int k, int s, int p);
    return calc_out_dim(w, k, s, p);
  endfunction

  function automatic int calc_vp(int h, int k, int s, int p);
    return calc_out_dim(h, k, s, p);
  endfunction

  function automatic int calc_ncol(int w, int h, int k, int s, int p);
    return calc_hp(w, k, s, p) * calc_vp(h, k, s, p);
  endfunction

  function automatic int calc_nrow(int c, int k);
    return c * k * k;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/im2col_frame_buffer.sv
// Full-frame pixel store: raster-addressed write, N_RD combinational reads by signed
// (y, x) coordinate returning zero outside the image.
module im2col_frame_buffer
  import im2col_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 4,
  parameter int IMAGE_HEIGHT = 4,
  parameter int CHANNELS     = 1,
  parameter int DATA_WIDTH   = 8,
  parameter int N_RD         = 4,
  parameter int CW           = 5
) (
  input  logic                                     clk,
  input  logic                                     i_we,
  input  logic [clog2_min1(IMAGE_WIDTH*IMAGE_HEIGHT)-1:0] i_waddr,
  input  logic [CHANNELS*DATA_WIDTH-1:0]           i_wdata,
  input  logic [N_RD*CW-1:0]                       i_ry,
  input  logic [N_RD*CW-1:0]                       i_rx,
  output logic [N_RD*CHANNELS*DATA_WIDTH-1:0]      o_rdata
);

  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int AW = clog2_min1(IMAGE_WIDTH * IMAGE_HEIGHT);

  logic [PW-1:0]        r_mem [IMAGE_WIDTH*IMAGE_HEIGHT];
  logic signed [CW-1:0] w_y;
  logic signed [CW-1:0] w_x;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_comb begin
    o_rdata = '0;
    w_y     = '0;
    w_x     = '0;
    for (int i = 0; i < N_RD; i++) begin
      w_y = $signed(i_ry[i*CW +: CW]);
      w_x = $signed(i_rx[i*CW +: CW]);
      if (w_y >= 0 && int'(w_y) < IMAGE_HEIGHT && w_x >= 0 && int'(w_x) < IMAGE_WIDTH) begin
        o_rdata[i*PW +: PW] = r_mem[AW'(int'(w_y) * IMAGE_WIDTH + int'(w_x))];
      end
    end
  end

endmodule

// File: rtl/im2col_stream.sv
// Streaming im2col: loads one raster-order frame, then emits one im2col column per
// output transfer, with zero padding and stride applied at read time.
module im2col_stream
  import im2col_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 4,
  parameter int IMAGE_HEIGHT = 4,
  parameter int CHANNELS     = 1,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                         in_data,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                                                   out_last,
  output logic                                                   busy
);

  localparam int HP   = calc_hp(IMAGE_WIDTH, KERNEL_SIZE, STRIDE, PADDING);
  localparam int VP   = calc_vp(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING);
  localparam int NCOL = calc_ncol(IMAGE_WIDTH, IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING);
  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PIXW = clog2_min1(NPIX);
  localparam int CLW  = clog2_min1(NCOL);
  localparam int HW   = clog2_min1(HP);
  localparam int VW   = clog2_min1(VP);
  // One sign bit plus room for -PADDING .. dimension+PADDING.
  localparam int CW   = clog2_min1(IMAGE_WIDTH + IMAGE_HEIGHT + 2 * PADDING + 1) + 1;

  state_e            r_state;
  state_e            w_state_d;
  logic [PIXW-1:0]   r_pix;
  logic [CLW-1:0]    r_col;
  logic [HW-1:0]     r_ox;
  logic [VW-1:0]     r_oy;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_pix_last;
  logic              w_col_last;
  logic [KK*CW-1:0]  w_ry;
  logic [KK*CW-1:0]  w_rx;
  logic [KK*CHANNELS*DATA_WIDTH-1:0] w_rdata;

  assign w_pix_last = (r_pix == PIXW'(NPIX - 1));
  assign w_col_last = (r_col == CLW'(NCOL - 1));
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign out_last   = (r_state == StEmit) && w_col_last;
  assign busy       = !((r_state == StLoad) && (r_pix == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StLoad;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid && w_pix_last) w_state_d = StEmit;
      end
      StEmit: begin
        out_valid = 1'b1;
        if (out_ready && w_col_last) w_state_d = StLoad;
      end
      default: w_state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix <= '0;
      r_col <= '0;
      r_ox  <= '0;
      r_oy  <= '0;
    end else begin
      if (w_in_fire) r_pix <= w_pix_last ? '0 : r_pix + 1'b1;
      if (w_out_fire) begin
        if (w_col_last) begin
          r_col <= '0;
          r_ox  <= '0;
          r_oy  <= '0;
        end else begin
          r_col <= r_col + 1'b1;
          if (r_ox == HW'(HP - 1)) begin
            r_ox <= '0;
            r_oy <= r_oy + 1'b1;
          end else begin
            r_ox <= r_ox + 1'b1;
          end
        end
      end
    end
  end

  // Window tap coordinates; negative or past-edge values read back as zero padding.
  always_comb begin
    w_ry = '0;
    w_rx = '0;
    for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
      for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
        w_ry[(ky*KERNEL_SIZE+kx)*CW +: CW] = CW'(int'(r_oy) * STRIDE + ky - PADDING);
        w_rx[(ky*KERNEL_SIZE+kx)*CW +: CW] = CW'(int'(r_ox) * STRIDE + kx - PADDING);
      end
    end
  end

  im2col_frame_buffer #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT),
    .CHANNELS    (CHANNELS),
    .DATA_WIDTH  (DATA_WIDTH),
    .N_RD        (KK),
    .CW          (CW)
  ) u_frame_buffer (
    .clk    (clk),
    .i_we   (w_in_fire),
    .i_waddr(r_pix),
    .i_wdata(in_data),
    .i_ry   (w_ry),
    .i_rx   (w_rx),
    .o_rdata(w_rdata)
  );

  // Buffer returns taps with channels innermost; columns want channel-major rows.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < KK; k++) begin
        out_data[(c*KK+k)*DATA_WIDTH +: DATA_WIDTH] =
          w_rdata[(k*CHANNELS+c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_im2col_stream.sv
// Directed bench: four im2col_stream configurations sharing clock and reset, checked
// against hand-computed columns.
module tb_im2col_stream;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  out_last;
  logic [3:0]  busy;
  logic [7:0]  in_data_s;
  logic [15:0] in_data_d;
  logic [31:0] od_a;
  logic [71:0] od_b;
  logic [31:0] od_c;
  logic [63:0] od_d;

  logic [71:0] cap_d [16];
  logic        cap_l [16];
  int unsigned n_chk;
  int unsigned n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: K2 S1 P0
  im2col_stream #(.KERNEL_SIZE(2), .STRIDE(1), .PADDING(0), .CHANNELS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data_s), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(od_a), .out_last(out_last[0]), .busy(busy[0]));
  // B: K3 S1 P1
  im2col_stream #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .CHANNELS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data_s), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(od_b), .out_last(out_last[1]), .busy(busy[1]));
  // C: K2 S2 P0
  im2col_stream #(.KERNEL_SIZE(2), .STRIDE(2), .PADDING(0), .CHANNELS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data_s), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(od_c), .out_last(out_last[2]), .busy(busy[2]));
  // D: two channels, K2 S1 P0
  im2col_stream #(.KERNEL_SIZE(2), .STRIDE(1), .PADDING(0), .CHANNELS(2)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data_d), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_data(od_d), .out_last(out_last[3]), .busy(busy[3]));

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  function automatic logic [71:0] col_of(input int sel);
    case (sel)
      0:       return {40'b0, od_a};
      1:       return od_b;
      2:       return {40'b0, od_c};
      default: return {8'b0, od_d};
    endcase
  endfunction

  // Image pixel p holds p+1; second channel of D holds p+101.
  task automatic load_frame(input logic [3:0] mask);
    for (int p = 0; p < 16; p++) begin
      in_valid  = mask;
      in_data_s = 8'(p + 1);
      in_data_d = {8'(p + 101), 8'(p + 1)};
      @(negedge clk);
    end
    in_valid = '0;
  endtask

  task automatic drain(input int sel, input int n);
    out_ready[sel] = 1'b1;
    for (int j = 0; j < n; j++) begin
      cap_d[j] = col_of(sel);
      cap_l[j] = out_last[sel];
      @(negedge clk);
    end
    out_ready[sel] = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    in_data_s = '0;
    in_data_d = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 72'(in_ready), 72'hf);
    chk("rst_out_valid", 72'(out_valid), 72'h0);
    chk("rst_out_last", 72'(out_last), 72'h0);
    chk("rst_busy", 72'(busy), 72'h0);

    // Load all four at once; first accepted beat makes the blocks busy.
    in_valid  = 4'hf;
    in_data_s = 8'd1;
    in_data_d = {8'd101, 8'd1};
    @(negedge clk);
    chk("busy_after_beat0", 72'(busy), 72'hf);
    for (int p = 1; p < 16; p++) begin
      in_data_s = 8'(p + 1);
      in_data_d = {8'(p + 101), 8'(p + 1)};
      @(negedge clk);
    end
    in_valid = '0;
    chk("emit_out_valid", 72'(out_valid), 72'hf);
    chk("emit_in_ready", 72'(in_ready), 72'h0);

    drain(0, 9);
    chk("a_col0", cap_d[0], 72'h06050201);
    chk("a_col4", cap_d[4], 72'h0b0a0706);
    chk("a_col8", cap_d[8], 72'h100f0c0b);
    chk("a_last0", 72'(cap_l[0]), 72'h0);
    chk("a_last8", 72'(cap_l[8]), 72'h1);
    chk("a_in_ready_after", 72'(in_ready[0]), 72'h1);
    chk("a_out_valid_after", 72'(out_valid[0]), 72'h0);

    drain(1, 16);
    chk("b_col0", cap_d[0], 72'h06_05_00_02_01_00_00_00_00);
    chk("b_col5", cap_d[5], 72'h0b_0a_09_07_06_05_03_02_01);
    chk("b_col15", cap_d[15], 72'h00_00_00_00_10_0f_00_0c_0b);
    chk("b_last14", 72'(cap_l[14]), 72'h0);
    chk("b_last15", 72'(cap_l[15]), 72'h1);
    chk("b_in_ready_after", 72'(in_ready[1]), 72'h1);

    drain(2, 4);
    chk("c_col1", cap_d[1], 72'h08070403);
    chk("c_col3", cap_d[3], 72'h100f0c0b);
    chk("c_last3", 72'(cap_l[3]), 72'h1);
    chk("c_in_ready_after", 72'(in_ready[2]), 72'h1);

    drain(3, 9);
    chk("d_col0", cap_d[0], 72'h6a_69_66_65_06_05_02_01);
    chk("d_last8", 72'(cap_l[8]), 72'h1);
    chk("d_in_ready_after", 72'(in_ready[3]), 72'h1);

    // Backpressure at column 2 of A.
    load_frame(4'b0001);
    out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", {40'b0, od_a}, 72'h08070403);
      chk("stall_valid", 72'(out_valid[0]), 72'h1);
      @(negedge clk);
    end
    drain(0, 7);
    chk("stall_col2", cap_d[0], 72'h08070403);
    chk("stall_col3", cap_d[1], 72'h0a090605);
    chk("stall_last", 72'(cap_l[6]), 72'h1);

    // Reset in the middle of emission.
    load_frame(4'b0001);
    out_ready[0] = 1'b1;
    repeat (4) @(negedge clk);
    out_ready[0] = 1'b0;
    chk("pre_rst_col4", {40'b0, od_a}, 72'h0b0a0706);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 72'(out_valid[0]), 72'h0);
    chk("async_out_last", 72'(out_last[0]), 72'h0);
    chk("async_busy", 72'(busy[0]), 72'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 72'(in_ready[0]), 72'h1);
    load_frame(4'b0001);
    drain(0, 9);
    chk("rerun_col0", cap_d[0], 72'h06050201);
    chk("rerun_col8", cap_d[8], 72'h100f0c0b);
    chk("rerun_last8", 72'(cap_l[8]), 72'h1);
    chk("rerun_in_ready", 72'(in_ready[0]), 72'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/im2col_stream.md
IM2COL_STREAM -- requirements
Module: im2col_stream

Interface
REQ-001 Parameters SHALL be: IMAGE_WIDTH, default 4, pixels per row; IMAGE_HEIGHT, default 4, rows per frame; CHANNELS, default 1, channels per pixel; KERNEL_SIZE, default 2, square kernel edge; STRIDE, default 1, window step in both axes; PADDING, default 0, zero border width on every side; DATA_WIDTH, default 8, element width.
REQ-002 Derived constants SHALL be: HP = (IMAGE_WIDTH-KERNEL_SIZE+2*PADDING)/STRIDE+1; VP likewise with IMAGE_HEIGHT; NCOL = HP*VP; NROW = CHANNELS*KERNEL_SIZE*KERNEL_SIZE.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  input pixel beat valid.
REQ-006 in_ready  output  1  block accepts an input beat.
REQ-007 in_data  input  CHANNELS x DATA_WIDTH  one pixel, all channels, element [c] = channel c.
REQ-008 out_valid  output  1  output column valid.
REQ-009 out_ready  input  1  consumer accepts the column.
REQ-010 out_data  output  NROW x DATA_WIDTH  one im2col column.
REQ-011 out_last  output  1  high with the final column (index NCOL-1) of a frame.
REQ-012 busy  output  1  high whenever state is not LOAD with zero pixels received.

Function
REQ-013 An input transfer SHALL occur on a rising edge with in_valid && in_ready; an output transfer with out_valid && out_ready.
REQ-014 State machine SHALL have two states: LOAD (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-015 In LOAD, pixels SHALL arrive in raster order (row 0 col 0 first, column fastest); pixel counter counts 0..IMAGE_WIDTH*IMAGE_HEIGHT-1.
REQ-016 Transfer of the last pixel SHALL move LOAD->EMIT; out_valid is high on the next cycle (latency 1) with column 0.
REQ-017 Column j = oy*HP+ox SHALL have element r = c*K*K + ky*K + kx equal to image[c][oy*STRIDE+ky-PADDING][ox*STRIDE+kx-PADDING], or 0 where that coordinate lies outside the image.
REQ-018 Columns SHALL be emitted in increasing j; column counter advances only on an output transfer.
REQ-019 While out_valid && !out_ready, out_data and out_last SHALL hold stable.
REQ-020 Transfer of column NCOL-1 SHALL move EMIT->LOAD, clear both counters; in_ready high next cycle; input and output never overlap.
REQ-021 in_data while in_ready=0 SHALL be ignored; out_ready while out_valid=0 SHALL be ignored.
REQ-022 Row/column arithmetic SHALL use signed coordinates wide enough for -PADDING..IMAGE_WIDTH+PADDING; no wrap-around into adjacent rows.
REQ-023 PADDING=0, STRIDE=1, CHANNELS=1 SHALL yield columns identical to the existing combinational im2col_2d output for the same image.

Reset
REQ-024 rst_n low SHALL immediately force state LOAD, counters 0, out_valid 0, out_last 0, busy 0, in_ready 1 after release; frame buffer contents need not clear.
REQ-025 Reset mid-LOAD or mid-EMIT SHALL abandon the frame; the next frame after release completes correctly.

Structure
REQ-026 Package im2col_pkg SHALL hold the derived-constant functions (HP/VP/NCOL/NROW) and the state enum shared with im2col_2d benches.
REQ-027 One sub-module im2col_frame_buffer SHALL hold the IMAGE_HEIGHT x IMAGE_WIDTH x CHANNELS register array with write port (raster address) and combinational read-by-coordinate returning 0 out of bounds.

Verification
REQ-028 4x4, K=2, S=1, P=0, C=1, image 1..16 -> 9 columns; col0={1,2,5,6}, col8={11,12,15,16} with out_last=1, then in_ready=1.
REQ-029 Same image, K=3, P=1 -> 16 columns; col0={0,0,0,0,1,2,0,5,6}, col15={11,12,0,15,16,0,0,0,0}.
REQ-030 Same image, K=2, S=2 -> 4 columns; col1={3,4,7,8}, col3={11,12,15,16}.
REQ-031 C=2, channel1 = channel0+100, K=2, S=1 -> col0={1,2,5,6,101,102,105,106}.
REQ-032 K=2, S=1: out_ready low 3 cycles at col2 -> out_data held {3,4,7,8}, column counter unchanged, col3={5,6,9,10} follows.
REQ-033 rst_n pulsed during col4 emission -> out_valid 0 asynchronously, in_ready 1 after release; fresh frame 1..16 reproduces REQ-028 exactly.
